// File: rtl/pmem_types.sv
// ============================================================================
//  Module      : pmem_types (package)
//  Description : Shared beat width, beat-count helper and FSM state encoding
//                for the burst pmem responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmem_types;

   localparam int PMEM_BEAT_W = 64;

   // Number of 64-bit beats needed to move one cacheline of 2^s_offset bytes
   function automatic int beats(input int s_offset);
      return ((1 << s_offset) * 8) / PMEM_BEAT_W;
   endfunction

   // Responder FSM states, explicit 2-bit encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      BURST   = 2'd2,
      RECOVER = 2'd3
   } pmem_state_t;

endpackage

`default_nettype wire

// File: rtl/pmem_line_array.sv
// ============================================================================
//  Module      : pmem_line_array
//  Description : Synchronous single-port line-wide RAM. The read port always
//                returns the line addressed on the previous edge. No reset;
//                contents are only ever changed by a write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_line_array #(
   parameter int LINE_W = 256,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  index,
   input  logic [LINE_W-1:0] wline,
   output logic [LINE_W-1:0] rline
);

   logic [LINE_W-1:0] r_mem [2**IDX_W];

   // Write-first is irrelevant here: the responder never reads a line on the
   // same edge it commits one, so plain read-before-write is used.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[index] <= wline;
      end
      rline <= r_mem[index];
   end

endmodule

`default_nettype wire

// File: rtl/pmem_burst_responder.sv
// ============================================================================
//  Module      : pmem_burst_responder
//  Description : Far-end physical memory for the 64-bit burst pmem interface.
//                Accepts one line request, waits a programmable latency, then
//                streams (read) or absorbs (write) the line as consecutive
//                64-bit beats with pmem_resp high once per beat, followed by
//                a single RECOVER cycle.
//  Options     : PMEM_RANDOM_LATENCY_EN - adds 0..15 cycles of LFSR-driven
//                extra latency per request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_burst_responder
   import pmem_types::*;
#(
   parameter int s_offset = 5,
   parameter int s_lines  = 8,
   parameter int LATENCY  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  logic [31:0] pmem_address,
   input  logic [63:0] pmem_wdata,
   output logic        pmem_resp,
   output logic [63:0] pmem_rdata
);

   localparam int LINE_W  = (2**s_offset) * 8;
   localparam int BEATS   = beats(s_offset);
   localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LAT_W   = $clog2(LATENCY + 16) + 1;

   pmem_state_t          r_state;
   logic                 r_is_write;
   logic [s_lines-1:0]   r_index;
   logic [LAT_W-1:0]     r_lat_cnt;
   logic [BEAT_CW-1:0]   r_beat;
   logic [LINE_W-1:0]    r_buf;

   logic [s_lines-1:0]   w_req_index;
   logic [s_lines-1:0]   w_ram_index;
   logic [LAT_W-1:0]     w_lat_load;
   logic                 w_last_beat;
   logic                 w_wait_done;
   logic                 w_we;
   logic [LINE_W-1:0]    w_wline;
   logic [LINE_W-1:0]    w_rline;
   logic                 w_unused_addr;

   assign w_req_index   = pmem_address[s_offset+s_lines-1:s_offset];
   assign w_unused_addr = ^{pmem_address[31:s_offset+s_lines], pmem_address[s_offset-1:0]};

   // In IDLE the RAM is addressed straight from the request pins so that the
   // line is already on rline by the time even a 1-cycle WAIT finishes.
   assign w_ram_index = (r_state == IDLE) ? w_req_index : r_index;

   assign w_last_beat = (r_beat == BEAT_CW'(BEATS - 1));
   assign w_wait_done = (r_state == WAIT) && (r_lat_cnt == '0);

   // Commit only on the final beat; a reset arriving on that same edge wins.
   assign w_we = (r_state == BURST) && r_is_write && w_last_beat && !rst;

`ifdef PMEM_RANDOM_LATENCY_EN
   logic [7:0] r_lfsr;
   logic       w_lfsr_fb;

   assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_lat_load = LAT_W'(LATENCY - 1) + LAT_W'(r_lfsr[3:0]);

   // Free-running Fibonacci LFSR (taps 8,6,5,4) supplying latency jitter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      end
   end
`else
   assign w_lat_load = LAT_W'(LATENCY - 1);
`endif

   // Line committed to the array: buffered beats plus the beat on the pins now
   always_comb begin
      w_wline = r_buf;
      w_wline[int'(r_beat)*PMEM_BEAT_W +: PMEM_BEAT_W] = pmem_wdata;
   end

   // Control FSM: accept, count latency, step beats, one recovery cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_is_write <= 1'b0;
         r_index    <= '0;
         r_lat_cnt  <= '0;
         r_beat     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (pmem_read || pmem_write) begin
                  r_is_write <= pmem_write;
                  r_index    <= w_req_index;
                  r_lat_cnt  <= w_lat_load;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               if (r_lat_cnt == '0) begin
                  r_beat  <= '0;
                  r_state <= BURST;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end
            end
            BURST: begin
               if (w_last_beat) begin
                  r_beat  <= '0;
                  r_state <= RECOVER;
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
            RECOVER: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Line buffer: snapshot of the array for reads, beat collector for writes
   always_ff @(posedge clk) begin
      if (w_wait_done && !r_is_write) begin
         r_buf <= w_rline;
      end else if ((r_state == BURST) && r_is_write) begin
         r_buf[int'(r_beat)*PMEM_BEAT_W +: PMEM_BEAT_W] <= pmem_wdata;
      end
   end

   pmem_line_array #(
      .LINE_W (LINE_W),
      .IDX_W  (s_lines)
   ) u_array (
      .clk   (clk),
      .we    (w_we),
      .index (w_ram_index),
      .wline (w_wline),
      .rline (w_rline)
   );

   assign pmem_resp  = (r_state == BURST);
   assign pmem_rdata = ((r_state == BURST) && !r_is_write)
                     ? r_buf[int'(r_beat)*PMEM_BEAT_W +: PMEM_BEAT_W]
                     : '0;

endmodule

`default_nettype wire

// File: tb/tb_pmem_burst_responder.sv
// ============================================================================
//  Module      : tb_pmem_burst_responder
//  Description : Self-checking bench for pmem_burst_responder. A line-level
//                memory model supplies expected read beats; one negedge
//                process checks resp/rdata every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmem_burst_responder;

   localparam int LATENCY = 10;
   localparam int NB      = 4;
`ifdef PMEM_RANDOM_LATENCY_EN
   localparam int SPREAD  = 15;
`else
   localparam int SPREAD  = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pmem_read = 1'b0;
   logic        pmem_write = 1'b0;
   logic [31:0] pmem_address = '0;
   logic [63:0] pmem_wdata = '0;
   logic        pmem_resp;
   logic [63:0] pmem_rdata;

   always #5 clk = ~clk;

   pmem_burst_responder #(
      .s_offset (5),
      .s_lines  (8),
      .LATENCY  (LATENCY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Behavioural memory: 256 lines x 4 beats, zero at start
   logic [63:0] mem_model [256][NB];
   logic [63:0] exp_q [$];

   // Handshake between driver and checker
   int  txn_id     = 0;
   bit  txn_active = 1'b0;
   bit  txn_read   = 1'b0;
   int  req_cyc    = 0;

   int          seen_id    = 0;
   int          beats_seen = 0;
   int          last_lat   = 0;
   int          lat_min    = 1000;
   int          lat_max    = 0;
   logic [63:0] got [NB];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: protocol shape, latency window and read data
   always @(negedge clk) begin
      logic [63:0] e;
      if (txn_id != seen_id) begin
         seen_id    = txn_id;
         beats_seen = 0;
      end
      if (!txn_active) begin
         chk("idle_resp", {63'd0, pmem_resp}, 64'd0);
         chk("idle_rdata", pmem_rdata, 64'd0);
      end else if (pmem_resp) begin
         if (beats_seen == 0) begin
            last_lat = cyc - req_cyc;
            checks++;
            if (last_lat < LATENCY + 1 || last_lat > LATENCY + 1 + SPREAD) begin
               errors++;
               $display("FAIL latency: got %0d expected %0d..%0d", last_lat, LATENCY + 1, LATENCY + 1 + SPREAD);
            end
            if (last_lat < lat_min) lat_min = last_lat;
            if (last_lat > lat_max) lat_max = last_lat;
         end
         if (beats_seen >= NB) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got beat %0d expected at most %0d", beats_seen + 1, NB);
         end else if (txn_read) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            got[beats_seen] = pmem_rdata;
            chk("rdata", pmem_rdata, e);
         end
         beats_seen++;
      end else begin
         chk("quiet_rdata", pmem_rdata, 64'd0);
         if (beats_seen > 0 && beats_seen < NB) begin
            checks++;
            errors++;
            $display("FAIL beat_gap: got resp low after %0d beats expected %0d contiguous", beats_seen, NB);
         end
      end
   end

   // One request; abort_beat >= 0 pulses rst while that beat is on the bus.
   // Entered and left at #1 after a posedge with the DUT in IDLE.
   task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [255:0] line, input int abort_beat);
      int  idx;
      int  k;
      int  n;
      bit  finished;
      bit  aborted;
      idx        = int'(a[12:5]);
      txn_id++;
      txn_read   = !wr;
      txn_active = 1'b1;
      req_cyc    = cyc;
      if (txn_read) for (int b = 0; b < NB; b++) exp_q.push_back(mem_model[idx][b]);
      pmem_read    = rd;
      pmem_write   = wr;
      pmem_address = a;
      pmem_wdata   = {$urandom, $urandom};
      k = 0; n = 0; finished = 1'b0; aborted = 1'b0;
      while (!finished && n < LATENCY + 40) begin
         @(posedge clk); #1;
         n++;
         if (pmem_resp) begin
            if (k < NB) pmem_wdata = line[64*k +: 64];
            if (k == abort_beat) begin
               rst = 1'b1;
               @(posedge clk); #1;
               rst        = 1'b0;
               pmem_read  = 1'b0;
               pmem_write = 1'b0;
               txn_active = 1'b0;
               exp_q.delete();
               chk("abort_resp", {63'd0, pmem_resp}, 64'd0);
               aborted  = 1'b1;
               finished = 1'b1;
            end
            k++;
         end else if (k >= 1) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
            finished   = 1'b1;
            @(posedge clk); #1;
            txn_active = 1'b0;
         end
      end
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d beats expected %0d within %0d cycles", k, NB, LATENCY + 40);
         pmem_read  = 1'b0;
         pmem_write = 1'b0;
         txn_active = 1'b0;
         exp_q.delete();
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
      end else if (wr && !aborted) begin
         for (int b = 0; b < NB; b++) mem_model[idx][b] = line[64*b +: 64];
      end
   endtask

   initial begin
      logic [255:0] l20, la0, lb0, l80, rl;
      int op;
      logic [31:0] ra;
      for (int i = 0; i < 256; i++)
         for (int b = 0; b < NB; b++) mem_model[i][b] = '0;
      l20 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      la0 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
             64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
      lb0 = {64'hBBBB_3, 64'hBBBB_2, 64'hBBBB_1, 64'hBBBB_0};
      l80 = {64'h5555_0003, 64'h5555_0002, 64'h5555_0001, 64'h5555_0000};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_resp", {63'd0, pmem_resp}, 64'd0);
      chk("reset_rdata", pmem_rdata, 64'd0);

      // Cold read: zeros, exact latency in the fixed build
      txn(1'b1, 1'b0, 32'h0000_0040, '0, -1);
      chk("lit_cold_b0", got[0], 64'd0);
      chk("lit_cold_b3", got[3], 64'd0);
`ifndef PMEM_RANDOM_LATENCY_EN
      chk("lit_latency", 64'(last_lat), 64'(LATENCY + 1));
`endif

      // Write then read back from an unaligned address in the same line
      txn(1'b0, 1'b1, 32'h0000_0020, l20, -1);
      txn(1'b1, 1'b0, 32'h0000_003C, '0, -1);
      chk("lit_rb_b0", got[0], 64'h1111_1111_1111_1111);
      chk("lit_rb_b1", got[1], 64'h2222_2222_2222_2222);
      chk("lit_rb_b3", got[3], 64'h4444_4444_4444_4444);

      // Upper address bits alias onto the same line
      txn(1'b1, 1'b0, 32'h0000_2020, '0, -1);
      chk("lit_alias_b2", got[2], 64'h3333_3333_3333_3333);

      // Read and write together: write wins
      txn(1'b1, 1'b1, 32'h0000_0080, l80, -1);
      txn(1'b1, 1'b0, 32'h0000_0080, '0, -1);
      chk("lit_both_b3", got[3], 64'h5555_0003);

      // Reset during beat 2 of an overwrite leaves prior contents intact
      txn(1'b0, 1'b1, 32'h0000_00A0, la0, -1);
      txn(1'b0, 1'b1, 32'h0000_00A0, lb0, 2);
      txn(1'b1, 1'b0, 32'h0000_00A0, '0, -1);
      chk("lit_abort_b0", got[0], 64'hA0A0_0000_0000_0000);
      chk("lit_abort_b2", got[2], 64'hA2A2_0000_0000_0002);

      // Random mix over a few lines with aliasing upper bits
      for (int t = 0; t < 64; t++) begin
         op = int'($urandom_range(0, 2));
         ra = {$urandom} & 32'hFFFF_E01F;
         ra[12:5] = 8'($urandom_range(0, 5)) + 8'h10;
         rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         txn(op != 1, op != 0, ra, rl, -1);
      end

      // Back-to-back reads, used for the latency spread in the jitter build
      for (int t = 0; t < 64; t++) begin
         txn(1'b1, 1'b0, {$urandom} & 32'h0000_1FFF, '0, -1);
      end
`ifdef PMEM_RANDOM_LATENCY_EN
      checks++;
      if (lat_min == lat_max) begin
         errors++;
         $display("FAIL latency_spread: got min=%0d max=%0d expected distinct values", lat_min, lat_max);
      end
`endif

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pmem_burst_responder.md
Name: pmem_burst_responder

Overview:
Synthesizable physical-memory responder at the far end of the 64-bit burst pmem interface that the cacheline adaptor drives. It accepts one line-aligned read or write request at a time and waits a programmable latency. It then streams or absorbs the line as consecutive 64-bit beats, asserting pmem_resp once per beat. It is the on-chip and FPGA stand-in for DRAM beneath the arbiter/adaptor stack, and the bench target for full-system runs.

Parameters:
s_offset, 5, log2 bytes per cacheline; line = 2^s_offset*8 bits (256).
s_lines, 8, log2 number of lines stored (256 lines = 8 KiB).
LATENCY, 10, cycles from request acceptance to first beat (must be >= 1).

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  synchronous, active-high reset.
pmem_read  in  1  line read request; held until last beat.
pmem_write  in  1  line write request; held until last beat.
pmem_address  in  32  byte address; low s_offset bits ignored.
pmem_wdata  in  64  write beat, sampled while pmem_resp=1.
pmem_resp  out  1  high for exactly BEATS consecutive cycles per request.
pmem_rdata  out  64  read beat, valid while pmem_resp=1; 0 otherwise.

Behaviour:
- BEATS = line bits / 64 = 4 at default; beat k = line bits [64k+63:64k], ascending order, no critical-word-first.
- Index = pmem_address[s_offset+s_lines-1:s_offset]; upper bits alias.
- Reset: state IDLE, pmem_resp=0, pmem_rdata=0, latency/beat counters 0. The array is not cleared by rst; it is zero at time 0.
- FSM states: IDLE, WAIT, BURST, RECOVER.
- IDLE: if pmem_read or pmem_write, latch op, index, write flag; load lat_cnt = LATENCY-1; go to WAIT. Both read and write high means write wins.
- WAIT: decrement lat_cnt; at 0 go to BURST with beat=0. Request pins are ignored here; address changes after acceptance have no effect.
- BURST: pmem_resp=1 every cycle.
  - Read: pmem_rdata = beat `beat` of the latched line. The line is read from the array on WAIT exit and held in a 256-bit buffer.
  - Write: pmem_wdata is captured into the buffer at slot `beat`.
  - At beat=BEATS-1: a write commits the full buffer to the array on that edge; go to RECOVER.
- RECOVER: one cycle, pmem_resp=0, requests ignored; the initiator deasserts here. Then go to IDLE.
- Minimum request-to-first-resp latency is LATENCY+1 cycles (1 acceptance + LATENCY wait).
- Back-to-back: a request asserted in the cycle after RECOVER is accepted.
- Read after write to the same line returns the new data, since the commit completes before RECOVER.
- rst mid-WAIT or mid-BURST aborts immediately. A partial write is discarded and the array is unchanged.

Optional Feature:
PMEM_RANDOM_LATENCY_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) steps every cycle. On acceptance, lat_cnt = LATENCY-1 + lfsr[3:0], giving a latency range of LATENCY..LATENCY+15. This stresses arbiter and adaptor timing.
- Undefined: fixed LATENCY, no LFSR logic.

Decomposition:
- Package pmem_types:
  - PMEM_BEAT_W=64.
  - function beats(s_offset).
  - enum pmem_state_t {IDLE, WAIT, BURST, RECOVER}.
- Sub-module pmem_line_array: synchronous single-port line-wide RAM (clk, we, index, wline, rline), no reset. It is instantiated once by the responder and holds all storage.

Test Plan:
- Reset then read addr 0x0000_0040 → pmem_resp first high exactly LATENCY+1 cycles after request; 4 beats, all 64'h0; pmem_resp low in RECOVER.
- Write 0x0000_0020 with beats 64'h1111…,2222…,3333…,4444… → 4 resp cycles. A following read of 0x0000_003C (same line) returns the same 4 beats in order.
- Aliasing: write line at 0x0000_0020, read 0x0000_2020 (s_lines=8) → identical data.
- Assert both read and write at 0x80 → treated as write; a later read returns the written data.
- Pulse rst during beat 2 of a write to 0xA0 → resp drops next cycle, state IDLE. A subsequent read of 0xA0 returns the prior contents, not partial data.
- With PMEM_RANDOM_LATENCY_EN, 64 back-to-back reads → every first-beat latency is within [LATENCY+1, LATENCY+16], with at least 2 distinct values observed; data is correct.
